// File: rtl/uart_cmd_asm_if.sv
// rtl/uart_cmd_asm_if.sv - byte-in / command-out handshake bundle for uart_cmd_asm
interface uart_cmd_asm_if;
   logic [7:0]  rx_data;
   logic        rx_rdy;
   logic        clr_rx_rdy;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        cmd_ovr;
   logic        to_err;

   modport master (
      output rx_data, rx_rdy, clr_cmd_rdy,
      input  clr_rx_rdy, cmd, cmd_rdy, cmd_ovr, to_err
   );

   modport slave (
      input  rx_data, rx_rdy, clr_cmd_rdy,
      output clr_rx_rdy, cmd, cmd_rdy, cmd_ovr, to_err
   );
endinterface

// File: rtl/uart_cmd_asm.sv
// rtl/uart_cmd_asm.sv - pairs UART bytes high-first into 16-bit commands with gap timeout
module uart_cmd_asm #(
   parameter int TO_CYCLES = 100000
) (
   input  logic           clk,
   input  logic           rst,
   uart_cmd_asm_if.slave  bus
);
   localparam int CW = $clog2(TO_CYCLES + 1);

   typedef enum logic {WAIT_HI, WAIT_LO} state_t;

   state_t        state_q;
   logic          rx_rdy_q;
   logic [7:0]    hi_byte_q;
   logic [CW-1:0] cnt_q;
   logic [15:0]   cmd_q;
   logic          cmd_rdy_q, cmd_rdy_d;
   logic          cmd_ovr_q, cmd_ovr_d;
   logic          clr_rx_rdy_q;
   logic          to_err_q;
   logic          capture;
   logic          complete;

   // Rising edge of the receiver level only; a held level captures once.
   assign capture  = bus.rx_rdy & ~rx_rdy_q;
   assign complete = capture && (state_q == WAIT_LO);

   // Completion beats a same-edge clear, and a cleared slot is not an overrun.
   always_comb begin
      cmd_rdy_d = cmd_rdy_q;
      cmd_ovr_d = cmd_ovr_q;
      if (bus.clr_cmd_rdy) begin
         cmd_rdy_d = 1'b0;
         cmd_ovr_d = 1'b0;
      end
      if (complete) begin
         cmd_rdy_d = 1'b1;
         if (cmd_rdy_q && !bus.clr_cmd_rdy)
            cmd_ovr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= WAIT_HI;
         rx_rdy_q     <= 1'b0;
         hi_byte_q    <= 8'h00;
         cnt_q        <= '0;
         cmd_q        <= 16'h0000;
         cmd_rdy_q    <= 1'b0;
         cmd_ovr_q    <= 1'b0;
         clr_rx_rdy_q <= 1'b0;
         to_err_q     <= 1'b0;
      end else begin
         rx_rdy_q     <= bus.rx_rdy;
         clr_rx_rdy_q <= capture;
         to_err_q     <= 1'b0;
         cmd_rdy_q    <= cmd_rdy_d;
         cmd_ovr_q    <= cmd_ovr_d;
         case (state_q)
            WAIT_HI: begin
               if (capture) begin
                  hi_byte_q <= bus.rx_data;
                  cnt_q     <= CW'(TO_CYCLES);
                  state_q   <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               if (capture) begin
                  cmd_q   <= {hi_byte_q, bus.rx_data};
                  state_q <= WAIT_HI;
               end else if (cnt_q == '0) begin
                  hi_byte_q <= 8'h00;
                  to_err_q  <= 1'b1;
                  state_q   <= WAIT_HI;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= WAIT_HI;
         endcase
      end
   end

   assign bus.clr_rx_rdy = clr_rx_rdy_q;
   assign bus.cmd        = cmd_q;
   assign bus.cmd_rdy    = cmd_rdy_q;
   assign bus.cmd_ovr    = cmd_ovr_q;
   assign bus.to_err     = to_err_q;
endmodule

// File: tb/tb_uart_cmd_asm.sv
// tb/tb_uart_cmd_asm.sv - directed self-checking bench for uart_cmd_asm
module tb_uart_cmd_asm;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_rdy = 1'b0;
   logic        clr_cmd_rdy = 1'b0;
   logic        sel = 1'b0;   // 0: TO_CYCLES=100 instance, 1: TO_CYCLES=20 instance

   logic [15:0] cmd;
   logic        cmd_rdy, cmd_ovr, clr_rx_rdy, to_err;
   int          pass_cnt = 0;
   int          total_cnt = 0;
   int          clr_cnt = 0;

   uart_cmd_asm_if bus100 ();
   uart_cmd_asm_if bus20 ();

   assign bus100.rx_data     = rx_data;
   assign bus100.rx_rdy      = rx_rdy & ~sel;
   assign bus100.clr_cmd_rdy = clr_cmd_rdy & ~sel;
   assign bus20.rx_data      = rx_data;
   assign bus20.rx_rdy       = rx_rdy & sel;
   assign bus20.clr_cmd_rdy  = clr_cmd_rdy & sel;

   assign cmd        = sel ? bus20.cmd        : bus100.cmd;
   assign cmd_rdy    = sel ? bus20.cmd_rdy    : bus100.cmd_rdy;
   assign cmd_ovr    = sel ? bus20.cmd_ovr    : bus100.cmd_ovr;
   assign clr_rx_rdy = sel ? bus20.clr_rx_rdy : bus100.clr_rx_rdy;
   assign to_err     = sel ? bus20.to_err     : bus100.to_err;

   uart_cmd_asm #(.TO_CYCLES(100)) u_dut100 (.clk(clk), .rst(rst), .bus(bus100));
   uart_cmd_asm #(.TO_CYCLES(20))  u_dut20  (.clk(clk), .rst(rst), .bus(bus20));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      if (clr_rx_rdy) clr_cnt++;
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_rdy  = 1'b1;
      @(negedge clk);
      rx_rdy  = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total_cnt++; if (cmd !== 16'h0000) $display("FAIL reset_cmd got %h want 0000", cmd); else pass_cnt++;
      total_cnt++; if (cmd_rdy !== 1'b0) $display("FAIL reset_cmd_rdy got %b want 0", cmd_rdy); else pass_cnt++;
      total_cnt++; if (cmd_ovr !== 1'b0) $display("FAIL reset_cmd_ovr got %b want 0", cmd_ovr); else pass_cnt++;
      total_cnt++; if (clr_rx_rdy !== 1'b0) $display("FAIL reset_clr_rx_rdy got %b want 0", clr_rx_rdy); else pass_cnt++;
      total_cnt++; if (to_err !== 1'b0) $display("FAIL reset_to_err got %b want 0", to_err); else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      sel = 1'b0;
      clr_cnt = 0;
      send_byte(8'hA5);
      total_cnt++; if (clr_rx_rdy !== 1'b1) $display("FAIL basic_clr_pulse got %b want 1", clr_rx_rdy); else pass_cnt++;
      total_cnt++; if (cmd_rdy !== 1'b0) $display("FAIL basic_rdy_after_hi got %b want 0", cmd_rdy); else pass_cnt++;
      send_byte(8'h3C);
      total_cnt++; if (cmd !== 16'hA53C) $display("FAIL basic_cmd got %h want a53c", cmd); else pass_cnt++;
      total_cnt++; if (cmd_rdy !== 1'b1) $display("FAIL basic_cmd_rdy got %b want 1", cmd_rdy); else pass_cnt++;
      total_cnt++; if (cmd_ovr !== 1'b0) $display("FAIL basic_cmd_ovr got %b want 0", cmd_ovr); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (clr_cnt !== 2) $display("FAIL basic_clr_count got %0d want 2", clr_cnt); else pass_cnt++;
      total_cnt++; if (clr_rx_rdy !== 1'b0) $display("FAIL basic_clr_width got %b want 0", clr_rx_rdy); else pass_cnt++;
      pulse_clr();
      total_cnt++; if (cmd_rdy !== 1'b0) $display("FAIL basic_clear got %b want 0", cmd_rdy); else pass_cnt++;
   endtask

   task automatic test_hold_level();
      sel = 1'b0;
      clr_cnt = 0;
      @(negedge clk);
      rx_data = 8'h11;
      rx_rdy  = 1'b1;
      repeat (50) @(negedge clk);
      rx_rdy  = 1'b0;
      total_cnt++; if (clr_cnt !== 1) $display("FAIL hold_clr_count got %0d want 1", clr_cnt); else pass_cnt++;
      total_cnt++; if (cmd_rdy !== 1'b0) $display("FAIL hold_cmd_rdy got %b want 0", cmd_rdy); else pass_cnt++;
      send_byte(8'h22);
      total_cnt++; if (cmd !== 16'h1122) $display("FAIL hold_cmd got %h want 1122", cmd); else pass_cnt++;
      total_cnt++; if (cmd_rdy !== 1'b1) $display("FAIL hold_cmd_rdy2 got %b want 1", cmd_rdy); else pass_cnt++;
      pulse_clr();
   endtask

   task automatic test_timeout();
      sel = 1'b1;
      send_byte(8'h7E);
      repeat (20) @(negedge clk);
      total_cnt++; if (to_err !== 1'b0) $display("FAIL timeout_early got %b want 0", to_err); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (to_err !== 1'b1) $display("FAIL timeout_pulse got %b want 1", to_err); else pass_cnt++;
      total_cnt++; if (cmd_rdy !== 1'b0) $display("FAIL timeout_cmd_rdy got %b want 0", cmd_rdy); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (to_err !== 1'b0) $display("FAIL timeout_width got %b want 0", to_err); else pass_cnt++;
      send_byte(8'h01);
      send_byte(8'h02);
      total_cnt++; if (cmd !== 16'h0102) $display("FAIL timeout_next_cmd got %h want 0102", cmd); else pass_cnt++;
      pulse_clr();
   endtask

   task automatic test_timeout_boundary();
      sel = 1'b1;
      send_byte(8'h55);
      repeat (19) @(negedge clk);
      send_byte(8'hAA);
      total_cnt++; if (cmd !== 16'h55AA) $display("FAIL boundary_cmd got %h want 55aa", cmd); else pass_cnt++;
      total_cnt++; if (cmd_rdy !== 1'b1) $display("FAIL boundary_cmd_rdy got %b want 1", cmd_rdy); else pass_cnt++;
      total_cnt++; if (to_err !== 1'b0) $display("FAIL boundary_to_err got %b want 0", to_err); else pass_cnt++;
      pulse_clr();
      sel = 1'b0;
   endtask

   task automatic test_overrun();
      sel = 1'b0;
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h56);
      send_byte(8'h78);
      total_cnt++; if (cmd !== 16'h5678) $display("FAIL ovr_cmd got %h want 5678", cmd); else pass_cnt++;
      total_cnt++; if (cmd_rdy !== 1'b1) $display("FAIL ovr_cmd_rdy got %b want 1", cmd_rdy); else pass_cnt++;
      total_cnt++; if (cmd_ovr !== 1'b1) $display("FAIL ovr_flag got %b want 1", cmd_ovr); else pass_cnt++;
      pulse_clr();
      total_cnt++; if (cmd_rdy !== 1'b0) $display("FAIL ovr_clr_rdy got %b want 0", cmd_rdy); else pass_cnt++;
      total_cnt++; if (cmd_ovr !== 1'b0) $display("FAIL ovr_clr_flag got %b want 0", cmd_ovr); else pass_cnt++;
      total_cnt++; if (cmd !== 16'h5678) $display("FAIL ovr_cmd_hold got %h want 5678", cmd); else pass_cnt++;
   endtask

   task automatic test_same_edge();
      sel = 1'b0;
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'hBE);
      @(negedge clk);
      rx_data     = 8'hEF;
      rx_rdy      = 1'b1;
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      rx_rdy      = 1'b0;
      clr_cmd_rdy = 1'b0;
      total_cnt++; if (cmd !== 16'hBEEF) $display("FAIL same_edge_cmd got %h want beef", cmd); else pass_cnt++;
      total_cnt++; if (cmd_rdy !== 1'b1) $display("FAIL same_edge_rdy got %b want 1", cmd_rdy); else pass_cnt++;
      total_cnt++; if (cmd_ovr !== 1'b0) $display("FAIL same_edge_ovr got %b want 0", cmd_ovr); else pass_cnt++;
   endtask

   task automatic test_async_reset();
      sel = 1'b0;
      send_byte(8'h33);
      total_cnt++; if (cmd_rdy !== 1'b1) $display("FAIL arst_pre_rdy got %b want 1", cmd_rdy); else pass_cnt++;
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      total_cnt++; if (cmd !== 16'h0000) $display("FAIL arst_cmd got %h want 0000", cmd); else pass_cnt++;
      total_cnt++; if (cmd_rdy !== 1'b0) $display("FAIL arst_cmd_rdy got %b want 0", cmd_rdy); else pass_cnt++;
      total_cnt++; if (cmd_ovr !== 1'b0) $display("FAIL arst_cmd_ovr got %b want 0", cmd_ovr); else pass_cnt++;
      total_cnt++; if (clr_rx_rdy !== 1'b0) $display("FAIL arst_clr_rx_rdy got %b want 0", clr_rx_rdy); else pass_cnt++;
      total_cnt++; if (to_err !== 1'b0) $display("FAIL arst_to_err got %b want 0", to_err); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      send_byte(8'h44);
      total_cnt++; if (cmd_rdy !== 1'b0) $display("FAIL arst_hi_only got %b want 0", cmd_rdy); else pass_cnt++;
      send_byte(8'h55);
      total_cnt++; if (cmd !== 16'h4455) $display("FAIL arst_next_cmd got %h want 4455", cmd); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold_level();
      test_timeout();
      test_timeout_boundary();
      test_overrun();
      test_same_edge();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
